// File: rtl/regfile_sb_if.sv
// Write, read and scoreboard signals of regfile_sb, bundled for the decode/writeback side.
// The master drives issue and writeback; the slave is the register file itself.
interface regfile_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  localparam int NREGS = 1 << ADDR_W;

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [ADDR_W-1:0] raddr1;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;
  logic              busy_set;
  logic [ADDR_W-1:0] busy_addr;
  logic              rs1_busy;
  logic              rs2_busy;
  logic [ADDR_W:0]   busy_cnt;
  logic [NREGS-1:0]  wr_onehot;

  modport master (
    output we, waddr, wdata, raddr1, raddr2, busy_set, busy_addr,
    input  rdata1, rdata2, rs1_busy, rs2_busy, busy_cnt, wr_onehot
  );

  modport slave (
    input  we, waddr, wdata, raddr1, raddr2, busy_set, busy_addr,
    output rdata1, rdata2, rs1_busy, rs2_busy, busy_cnt, wr_onehot
  );
endinterface

// File: rtl/regfile_sb.sv
// Register file with one-hot write decode, two combinational read ports, optional
// write-to-read bypass, hardwired zero register and a busy scoreboard for pending writebacks.
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input logic         clk,
  input logic         rst,
  regfile_sb_if.slave bus
);
  localparam int NREGS = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0]  dec;
  logic [NREGS-1:0]  busy;
  logic [NREGS-1:0]  busy_next;
  logic [NREGS-1:0]  onehot_q;
  logic [ADDR_W:0]   cnt;
  logic              zero1, zero2;
  logic              byp1, byp2;
  logic              wr_zero;

  // NOTE: every combinational output gets its default first, so no path leaves it unassigned and no latch appears.
  always_comb begin
    dec = '0;
    if (bus.we) dec[bus.waddr] = 1'b1;
    if (ZERO_REG) dec[0] = 1'b0;
  end

  assign wr_zero = ZERO_REG && (bus.waddr == '0);
  assign zero1   = ZERO_REG && (bus.raddr1 == '0);
  assign zero2   = ZERO_REG && (bus.raddr2 == '0);
  assign byp1    = BYPASS && bus.we && (bus.waddr == bus.raddr1) && !wr_zero;
  assign byp2    = BYPASS && bus.we && (bus.waddr == bus.raddr2) && !wr_zero;

  // NOTE: the storage array is reset on purpose: reads must return zero immediately after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (dec[i]) regs[i] <= bus.wdata;
      end
    end
  end

  always_comb begin
    bus.rdata1 = regs[bus.raddr1];
    if (byp1)  bus.rdata1 = bus.wdata;
    if (zero1) bus.rdata1 = '0;
    bus.rdata2 = regs[bus.raddr2];
    if (byp2)  bus.rdata2 = bus.wdata;
    if (zero2) bus.rdata2 = '0;
  end

  // Clear is applied before set, so an issue to the register being written back wins.
  always_comb begin
    busy_next = busy;
    if (bus.we)       busy_next[bus.waddr]     = 1'b0;
    if (bus.busy_set) busy_next[bus.busy_addr] = 1'b1;
    if (ZERO_REG)     busy_next[0]             = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= '0;
      onehot_q <= '0;
    end else begin
      busy     <= busy_next;
      onehot_q <= dec;
    end
  end

  always_comb begin
    cnt = '0;
    for (int i = 0; i < NREGS; i++) cnt = cnt + {{ADDR_W{1'b0}}, busy[i]};
  end

  assign bus.rs1_busy  = busy[bus.raddr1] && !byp1 && !zero1;
  assign bus.rs2_busy  = busy[bus.raddr2] && !byp2 && !zero2;
  assign bus.busy_cnt  = cnt;
  assign bus.wr_onehot = onehot_q;
endmodule
